// File: rtl/systolic_result_collector.sv
// Deskews the bottom-edge result wavefront into whole rows and queues them for a valid/ready consumer; row visible N cycles after its column 0.
// Never stalls the array: a row arriving at a full FIFO without a pop is dropped and flagged sticky. Optional ReLU via SYSTOLIC_COLLECTOR_RELU_EN.
module systolic_result_collector #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUMBER_OF_BUFFERS = 4,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [DATA_WIDTH*NUMBER_OF_BUFFERS-1:0] systolic_array_links_in,
  input  logic                                    array_valid_in,
  input  logic                                    clear,
  output logic [DATA_WIDTH*NUMBER_OF_BUFFERS-1:0] output_data,
  output logic                                    output_valid,
  input  logic                                    output_ready,
  output logic [$clog2(FIFO_DEPTH):0]             fill_level,
  output logic                                    overflow
);
  localparam int N     = NUMBER_OF_BUFFERS;
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ROW_W = DW * N;

  logic [ROW_W-1:0] aligned;
  logic [ROW_W-1:0] row_in;
  logic             row_done;

  // Column i waits N-1-i cycles so every column of a row lines up with column N-1.
  for (genvar i = 0; i < N; i++) begin : g_col
    localparam int D = N - 1 - i;
    if (D == 0) begin : g_pass
      assign aligned[i*DW +: DW] = systolic_array_links_in[i*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] dly [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dly[k] <= '0;
        end else begin
          dly[0] <= systolic_array_links_in[i*DW +: DW];
          for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end
      assign aligned[i*DW +: DW] = dly[D-1];
    end
  end

  if (N == 1) begin : g_vsr_none
    assign row_done = array_valid_in;
  end else begin : g_vsr
    logic [N-2:0] vsr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     vsr <= '0;
      else if (clear) vsr <= '0;
      else            vsr <= (vsr << 1) | (N-1)'(array_valid_in);
    end
    assign row_done = vsr[N-2];
  end

  always_comb begin
    row_in = aligned;
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    for (int i = 0; i < N; i++) begin
      if (aligned[i*DW + DW - 1]) row_in[i*DW +: DW] = '0;
    end
`endif
  end

  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign fill_level   = wptr - rptr;
  assign full         = (fill_level == (AW+1)'(FIFO_DEPTH));
  assign output_valid = (fill_level != '0);
  assign pop          = output_valid && output_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push         = row_done && (!full || pop);
  assign drop         = row_done && full && !pop;
  assign output_data  = output_valid ? mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr[AW-1:0]] <= row_in;
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized and directed bench: queue-based reference model of the skewed row stream and the row FIFO, checked every cycle.
module tb_systolic_result_collector;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int RW    = DW * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] links = '0;
  logic          array_valid_in = 1'b0;
  logic          clear = 1'b0;
  logic          output_ready = 1'b0;
  logic [RW-1:0] output_data;
  logic          output_valid;
  logic [2:0]    fill_level;
  logic          overflow;

  systolic_result_collector #(
    .DATA_WIDTH(DW), .NUMBER_OF_BUFFERS(N), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .systolic_array_links_in(links), .array_valid_in(array_valid_in),
    .clear(clear), .output_data(output_data), .output_valid(output_valid),
    .output_ready(output_ready), .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int done; logic [RW-1:0] d; } flight_t;
  bit            vld_at [int];
  logic [RW-1:0] row_at [int];
  flight_t       flight [$];
  logic [RW-1:0] exp_q  [$];
  bit            m_ovf = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    for (int i = 0; i < N; i++)
      if ($signed(r[i*DW +: DW]) < 0) o[i*DW +: DW] = '0;
`endif
    return o;
  endfunction

  // Reference model: a row issued in cycle t becomes complete in cycle t+N-1 and is then offered to a bounded queue.
  always @(posedge clk or negedge rst_n) begin
    bit pop;
    bit was_full;
    if (!rst_n || clear) begin
      flight.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop      = (exp_q.size() > 0) && output_ready;
      was_full = (exp_q.size() >= DEPTH);
      if (array_valid_in) flight.push_back('{cyc + N - 1, row_at[cyc]});
      if (pop) void'(exp_q.pop_front());
      if (flight.size() > 0 && flight[0].done == cyc) begin
        if (!was_full || pop) exp_q.push_back(relu(flight[0].d));
        else m_ovf = 1'b1;
        void'(flight.pop_front());
      end
    end
  end

  // Monitor: whatever the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    chk("output_valid", 32'(output_valid), 32'(exp_q.size() != 0));
    chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() != 0) chk("output_data", output_data, exp_q[0]);
  end

  task automatic step(input bit v, input logic [RW-1:0] row, input bit rdy, input bit clr);
    @(negedge clk);
    vld_at[cyc] = v;
    row_at[cyc] = row;
    for (int i = 0; i < N; i++) begin
      if (vld_at.exists(cyc - i) && vld_at[cyc - i]) links[i*DW +: DW] = row_at[cyc - i][i*DW +: DW];
      else links[i*DW +: DW] = 8'($urandom);
    end
    array_valid_in = v;
    output_ready   = rdy;
    clear          = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic rows(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b1, $urandom, rdy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(output_valid), 32'd0);
    chk({tag, "_fill"}, 32'(fill_level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_data"}, output_data, 32'd0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    #1 rst_n = 1'b1;
  endtask

  initial begin
    idle(3, 1'b0);
    check_zero("reset");
    rst_n = 1'b1;
    do idle(1, 1'b0); while (cyc < 9);

    // Single row issued in cycle 10 must appear in cycle 14.
    step(1'b1, 32'h44332211, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("single_not_early", 32'(output_valid), 32'd0);
    idle(1, 1'b0);
    chk("single_valid", 32'(output_valid), 32'd1);
    chk("single_data", output_data, 32'h44332211);
    chk("single_fill", 32'(fill_level), 32'd1);
    idle(3, 1'b1);

    // Fill to four, fifth row overflows, then drain in order.
    rows(4, 1'b0);
    idle(4, 1'b0);
    rows(1, 1'b0);
    idle(5, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    idle(6, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full FIFO with push and pop in the same cycle.
    rows(4, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 32'h5A6B7C8D, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("pushpop_fill", 32'(fill_level), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    idle(6, 1'b1);

    // Clear with three rows queued and two in the skew pipeline.
    rows(3, 1'b0);
    idle(4, 1'b0);
    rows(2, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("clear_fill", 32'(fill_level), 32'd0);
    idle(6, 1'b1);

    // Sign-bit columns, with and without ReLU.
    step(1'b1, 32'h7F807F80, 1'b0, 1'b0);
    idle(4, 1'b0);
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    chk("relu_data", output_data, 32'h7F007F00);
`else
    chk("relu_data", output_data, 32'h7F807F80);
`endif
    idle(2, 1'b1);

    // Random traffic with an asynchronous reset mid-burst.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) async_reset();
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 2));
    end
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before time 200000");
    $fatal(1, "watchdog");
  end

endmodule
